// File: rtl/cnu_min_accum.sv
// rtl/cnu_min_accum.sv - CNU min-sum row accumulator: folds NPAIR (min1,min2,cp) pairs into row min1/min2/idx
// Optional offset min-sum at the output register when OFFSET_MS_EN is defined.
module cnu_min_accum #(
  parameter int W     = 6,
  parameter int NPAIR = 4,
  parameter int IW    = 3,
  parameter int BETA  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-2:0]  min1_in,
  input  logic [W-2:0]  min2_in,
  input  logic          cp_in,
  output logic          out_valid,
  output logic [W-2:0]  min1,
  output logic [W-2:0]  min2,
  output logic [IW-1:0] idx,
  output logic          busy
);

  localparam int M  = W - 1;
  localparam int CW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

`ifdef OFFSET_MS_EN
  localparam logic [M-1:0] OFS = M'(BETA);
`else
  localparam logic [M-1:0] OFS = '0;
`endif

  logic [CW-1:0] pair_cnt;
  logic [M-1:0]  acc_min1;
  logic [M-1:0]  acc_min2;
  logic [IW-1:0] acc_idx;

  logic [IW-1:0] bi;
  logic          last;
  logic [M-1:0]  mrg_min1;
  logic [M-1:0]  mrg_min2;
  logic [IW-1:0] mrg_idx;
  logic [CW-1:0] cnt_next;

  // Floor-at-zero subtraction; identity when the offset is zero.
  function automatic logic [M-1:0] sat0(input logic [M-1:0] v);
    return (v > OFS) ? (v - OFS) : '0;
  endfunction

  assign bi       = IW'({pair_cnt, cp_in});
  assign last     = (pair_cnt == CW'(NPAIR - 1));
  assign cnt_next = last ? '0 : (pair_cnt + CW'(1));

  // Strict less-than keeps the earlier pair as min1 on ties.
  always_comb begin
    mrg_min1 = acc_min1;
    mrg_min2 = acc_min2;
    mrg_idx  = acc_idx;
    if (pair_cnt == '0) begin
      mrg_min1 = min1_in;
      mrg_min2 = min2_in;
      mrg_idx  = IW'(cp_in);
    end else if (min1_in < acc_min1) begin
      mrg_min1 = min1_in;
      mrg_min2 = (acc_min1 < min2_in) ? acc_min1 : min2_in;
      mrg_idx  = bi;
    end else begin
      mrg_min2 = (acc_min2 < min1_in) ? acc_min2 : min1_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pair_cnt  <= '0;
      acc_min1  <= '0;
      acc_min2  <= '0;
      acc_idx   <= '0;
      min1      <= '0;
      min2      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        acc_min1 <= mrg_min1;
        acc_min2 <= mrg_min2;
        acc_idx  <= mrg_idx;
        pair_cnt <= cnt_next;
        busy     <= (cnt_next != '0);
        if (last) begin
          min1      <= sat0(mrg_min1);
          min2      <= sat0(mrg_min2);
          idx       <= mrg_idx;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnu_min_accum.sv
// tb/tb_cnu_min_accum.sv - self-checking bench for cnu_min_accum with a sort-based row reference model
module tb_cnu_min_accum;

  localparam int W     = 6;
  localparam int NPAIR = 4;
  localparam int IW    = 3;
  localparam int M     = W - 1;
`ifdef OFFSET_MS_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [M-1:0]  min1_in = '0;
  logic [M-1:0]  min2_in = '0;
  logic          cp_in = 1'b0;
  logic          out_valid;
  logic [M-1:0]  min1;
  logic [M-1:0]  min2;
  logic [IW-1:0] idx;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  cnu_min_accum #(.W(W), .NPAIR(NPAIR), .IW(IW), .BETA(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .min1_in(min1_in), .min2_in(min2_in),
    .cp_in(cp_in), .out_valid(out_valid), .min1(min1), .min2(min2), .idx(idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Every output pulse seen at the falling edge is recorded with its cycle stamp.
  int got_m1[$], got_m2[$], got_idx[$], got_cyc[$];
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_m1.push_back(int'(min1));
      got_m2.push_back(int'(min2));
      got_idx.push_back(int'(idx));
      got_cyc.push_back(cycle);
    end
  end

  int r1[NPAIR], r2[NPAIR], rc[NPAIR];
  int exp_m1[$], exp_m2[$], exp_idx[$];

  task automatic clear_all();
    got_m1.delete(); got_m2.delete(); got_idx.delete(); got_cyc.delete();
    exp_m1.delete(); exp_m2.delete(); exp_idx.delete();
  endtask

  task automatic set_pair(input int p, input int a, input int b, input int c);
    r1[p] = a; r2[p] = b; rc[p] = c;
  endtask

  // Reference: min1/min2 are the two smallest of all 2*NPAIR magnitudes; idx is the
  // edge of the earliest pair holding the minimum.
  task automatic model_push();
    int vals[$];
    int best;
    best = 0;
    for (int p = 0; p < NPAIR; p++) begin
      vals.push_back(r1[p]);
      vals.push_back(r2[p]);
      if (r1[p] < r1[best]) best = p;
    end
    vals.sort();
    exp_m1.push_back((vals[0] > OFS) ? vals[0] - OFS : 0);
    exp_m2.push_back((vals[1] > OFS) ? vals[1] - OFS : 0);
    exp_idx.push_back(2 * best + rc[best]);
  endtask

  task automatic random_row(input int range);
    int a, b;
    for (int p = 0; p < NPAIR; p++) begin
      a = $urandom_range(0, range);
      b = $urandom_range(0, range);
      if (a <= b) set_pair(p, a, b, $urandom_range(0, 1));
      else        set_pair(p, b, a, $urandom_range(0, 1));
    end
  endtask

  task automatic drive_row(input int gap);
    for (int p = 0; p < NPAIR; p++) begin
      @(negedge clk);
      min1_in = M'(r1[p]); min2_in = M'(r2[p]); cp_in = rc[p][0]; in_valid = 1'b1;
      if (p != NPAIR - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0; min1_in = M'($urandom); min2_in = M'($urandom); cp_in = 1'($urandom);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic compare_pulses(input string name);
    checks++;
    if (got_m1.size() !== exp_m1.size()) begin
      errors++;
      $display("FAIL %s pulse_count got=%0d exp=%0d", name, got_m1.size(), exp_m1.size());
    end
    for (int i = 0; i < exp_m1.size() && i < got_m1.size(); i++) begin
      checks++;
      if (got_m1[i] !== exp_m1[i] || got_m2[i] !== exp_m2[i] || got_idx[i] !== exp_idx[i]) begin
        errors++;
        $display("FAIL %s row%0d got min1=%0d min2=%0d idx=%0d exp min1=%0d min2=%0d idx=%0d",
                 name, i, got_m1[i], got_m2[i], got_idx[i], exp_m1[i], exp_m2[i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; min1_in = M'($urandom); min2_in = 5'd31; cp_in = 1'($urandom);
      checks++;
      if (out_valid !== 1'b0 || min1 !== '0 || min2 !== '0 || idx !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset got ov=%b min1=%0d min2=%0d idx=%0d busy=%b exp all 0",
                 out_valid, min1, min2, idx, busy);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    clear_all();
  endtask

  task automatic test_row();
    clear_all();
    set_pair(0, 9, 20, 1); set_pair(1, 3, 12, 0); set_pair(2, 7, 8, 1); set_pair(3, 5, 30, 0);
    exp_m1.push_back(3 - OFS); exp_m2.push_back(5 - OFS); exp_idx.push_back(2);
    drive_row(0);
    idle(2);
    compare_pulses("row");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL row_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_tie();
    clear_all();
    set_pair(0, 4, 10, 0); set_pair(1, 4, 6, 1); set_pair(2, 11, 12, 0); set_pair(3, 15, 31, 1);
    exp_m1.push_back(4 - OFS); exp_m2.push_back(4 - OFS); exp_idx.push_back(0);
    drive_row(0);
    idle(2);
    compare_pulses("tie");
  endtask

  task automatic test_floor();
    clear_all();
    set_pair(0, 0, 1, 0); set_pair(1, 9, 9, 0); set_pair(2, 9, 9, 1); set_pair(3, 9, 9, 0);
    exp_m1.push_back(0); exp_m2.push_back(1 - OFS); exp_idx.push_back(0);
    drive_row(1);
    idle(2);
    compare_pulses("floor");
  endtask

  task automatic test_back_to_back();
    clear_all();
    random_row(31); model_push(); drive_row(0);
    random_row(7);  model_push(); drive_row(0);
    set_pair(0, 1, 2, 1); set_pair(1, 31, 31, 0); set_pair(2, 31, 31, 1); set_pair(3, 0, 31, 1);
    exp_m1.push_back(0); exp_m2.push_back(1 - OFS); exp_idx.push_back(7);
    drive_row(2);
    idle(3);
    compare_pulses("back_to_back");
    if (got_cyc.size() >= 2) begin
      checks++;
      if (got_cyc[1] - got_cyc[0] !== NPAIR) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", got_cyc[1] - got_cyc[0], NPAIR);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    clear_all();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      min1_in = M'(p + 1); min2_in = 5'd2; cp_in = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b ov=%b exp 0 0", busy, out_valid);
    end
    set_pair(0, 6, 9, 0); set_pair(1, 8, 10, 1); set_pair(2, 2, 3, 0); set_pair(3, 20, 21, 1);
    exp_m1.push_back(2 - OFS); exp_m2.push_back(3 - OFS); exp_idx.push_back(4);
    drive_row(0);
    idle(3);
    compare_pulses("reset_mid_row");
  endtask

  task automatic test_random();
    clear_all();
    for (int r = 0; r < 40; r++) begin
      random_row(($urandom_range(0, 1) == 1) ? 31 : 5);
      model_push();
      drive_row($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    compare_pulses("random");
  endtask

  initial begin
    test_reset();
    test_row();
    test_tie();
    test_floor();
    test_back_to_back();
    test_reset_mid_row();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
